branch_update_queue: RTL and testbench

- Resolve-side companion to the tournament branch predictor.
- Fetch enqueues the prediction metadata for each predicted branch (component predictions, final prediction, BHR snapshot, PC).
- When execute resolves the oldest branch, the block pops it, compares outcome against prediction and drives the one-cycle training commands for the global predictor, local PHT and meta chooser.
- Also raises a mispredict pulse and squashes younger entries; sits between IF/EX and the predictor update ports.

---
 rtl/branch_update_queue.sv | 132 +++++++++++++
 tb/tb_branch_update_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_queue.sv
// Resolve-side queue for the tournament predictor: holds per-branch prediction
// metadata from fetch and turns each in-order resolve into one-cycle training commands.
module branch_update_queue #(
  parameter int DEPTH        = 4,
  parameter int pc_idx_start = 6,
  parameter int pc_idx_width = 4,
  parameter int bhr_width    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [31:0]               enq_pc,
  input  logic                      enq_global_pred,
  input  logic                      enq_local_pred,
  input  logic                      enq_final_pred,
  input  logic [bhr_width-1:0]      enq_bhr,
  input  logic                      res_valid,
  input  logic                      res_taken,
  input  logic                      flush,
  output logic                      upd_valid,
  output logic                      upd_br_en,
  output logic [pc_idx_width-1:0]   upd_idx,
  output logic [bhr_width-1:0]      upd_bhr,
  output logic                      upd_meta_valid,
  output logic                      upd_meta_to_global,
  output logic                      mispredict,
  output logic                      res_err,
  output logic [$clog2(DEPTH):0]    count,
  output logic [31:0]               stat_branches,
  output logic [31:0]               stat_mispredicts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [pc_idx_width-1:0] idxMem_q [DEPTH];
  logic [bhr_width-1:0]    bhrMem_q [DEPTH];
  logic [DEPTH-1:0]        gMem_q, lMem_q, fMem_q;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic                    updValid_q, updBrEn_q, metaValid_q, metaToGlobal_q;
  logic                    mispredict_q, resErr_q;
  logic [pc_idx_width-1:0] updIdx_q;
  logic [bhr_width-1:0]    updBhr_q;
  logic [31:0]             statBranches_q, statMispredicts_q;

  logic isFull, isEmpty, doRes, doEnq, isMis, clearAll;
  logic headG, headL, headF;
  logic unusedPcBits;

  // Only the index slice of the PC is kept; the rest is intentionally dropped.
  assign unusedPcBits = ^enq_pc;

  always_comb begin
    isFull   = (count_q == CW'(DEPTH));
    isEmpty  = (count_q == '0);
    headG    = gMem_q[head_q];
    headL    = lMem_q[head_q];
    headF    = fMem_q[head_q];
    doRes    = res_valid && !isEmpty;
    isMis    = doRes && (headF != res_taken);
    clearAll = isMis || flush;
    doEnq    = enq_valid && !isFull && !clearAll;
  end

  always_ff @(posedge clk) begin
    if (doEnq) begin
      idxMem_q[tail_q] <= enq_pc[pc_idx_start +: pc_idx_width];
      bhrMem_q[tail_q] <= enq_bhr;
      gMem_q[tail_q]   <= enq_global_pred;
      lMem_q[tail_q]   <= enq_local_pred;
      fMem_q[tail_q]   <= enq_final_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      updValid_q        <= 1'b0;
      updBrEn_q         <= 1'b0;
      updIdx_q          <= '0;
      updBhr_q          <= '0;
      metaValid_q       <= 1'b0;
      metaToGlobal_q    <= 1'b0;
      mispredict_q      <= 1'b0;
      resErr_q          <= 1'b0;
      statBranches_q    <= '0;
      statMispredicts_q <= '0;
    end else begin
      // A squash or flush discards everything behind the popped head.
      if (clearAll) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        head_q  <= head_q + PW'(doRes);
        tail_q  <= tail_q + PW'(doEnq);
        count_q <= count_q + CW'(doEnq) - CW'(doRes);
      end
      updValid_q     <= doRes;
      updBrEn_q      <= doRes && res_taken;
      updIdx_q       <= doRes ? idxMem_q[head_q] : '0;
      updBhr_q       <= doRes ? bhrMem_q[head_q] : '0;
      metaValid_q    <= doRes && (headG != headL);
      metaToGlobal_q <= doRes && (headG != headL) && (headG == res_taken);
      mispredict_q   <= isMis;
      resErr_q       <= res_valid && isEmpty;
      if (doRes && statBranches_q != '1)
        statBranches_q <= statBranches_q + 32'd1;
      if (isMis && statMispredicts_q != '1)
        statMispredicts_q <= statMispredicts_q + 32'd1;
    end
  end

  assign enq_ready          = !isFull;
  assign count              = count_q;
  assign upd_valid          = updValid_q;
  assign upd_br_en          = updBrEn_q;
  assign upd_idx            = updIdx_q;
  assign upd_bhr            = updBhr_q;
  assign upd_meta_valid     = metaValid_q;
  assign upd_meta_to_global = metaToGlobal_q;
  assign mispredict         = mispredict_q;
  assign res_err            = resErr_q;
  assign stat_branches      = statBranches_q;
  assign stat_mispredicts   = statMispredicts_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the resolve/train behaviour.
module tb_branch_update_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0] idx;
    logic       g;
    logic       l;
    logic       f;
    logic [3:0] bhr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, enq_valid, enq_global_pred, enq_local_pred, enq_final_pred;
  logic        res_valid, res_taken, flush;
  logic [31:0] enq_pc;
  logic [3:0]  enq_bhr;
  logic        enq_ready, upd_valid, upd_br_en, upd_meta_valid, upd_meta_to_global;
  logic        mispredict, res_err;
  logic [3:0]  upd_idx, upd_bhr;
  logic [2:0]  count;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  ent_t        modelQ[$];
  logic        expUpdValid, expBrEn, expMetaValid, expToGlobal, expMis, expResErr;
  logic [3:0]  expIdx, expBhr;
  logic [31:0] expBranches, expMispreds;

  branch_update_queue #(.DEPTH(DEPTH), .pc_idx_start(6), .pc_idx_width(4), .bhr_width(4)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_global_pred(enq_global_pred), .enq_local_pred(enq_local_pred),
    .enq_final_pred(enq_final_pred), .enq_bhr(enq_bhr),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_br_en(upd_br_en), .upd_idx(upd_idx), .upd_bhr(upd_bhr),
    .upd_meta_valid(upd_meta_valid), .upd_meta_to_global(upd_meta_to_global),
    .mispredict(mispredict), .res_err(res_err), .count(count),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-order list of branches; each resolve pops the oldest one.
  task automatic modelStep(input logic ev, input logic [31:0] pc, input logic g, input logic l,
                           input logic f, input logic [3:0] bhr, input logic rv, input logic rt,
                           input logic fl, input logic r);
    int sz;
    ent_t h, e;
    sz = modelQ.size();
    expUpdValid = 0; expBrEn = 0; expIdx = 0; expBhr = 0;
    expMetaValid = 0; expToGlobal = 0; expMis = 0; expResErr = 0;
    if (r) begin
      modelQ.delete();
      expBranches = 0;
      expMispreds = 0;
    end else begin
      expResErr = rv && (sz == 0);
      if (rv && sz > 0) begin
        h = modelQ.pop_front();
        expUpdValid  = 1;
        expBrEn      = rt;
        expIdx       = h.idx;
        expBhr       = h.bhr;
        expMetaValid = (h.g != h.l);
        expToGlobal  = expMetaValid && (h.g == rt);
        expMis       = (h.f != rt);
        if (expBranches != 32'hFFFF_FFFF) expBranches++;
        if (expMis && expMispreds != 32'hFFFF_FFFF) expMispreds++;
      end
      if (expMis || fl) modelQ.delete();
      else if (ev && sz < DEPTH) begin
        e.idx = 4'((pc >> 6) & 32'hF);
        e.g = g; e.l = l; e.f = f; e.bhr = bhr;
        modelQ.push_back(e);
      end
    end
  endtask

  // One cycle: drive inputs just after the falling edge, advance the model, land #1 after rise.
  task automatic applyStimulus(input logic ev, input logic [31:0] pc, input logic g, input logic l,
                               input logic f, input logic [3:0] bhr, input logic rv, input logic rt,
                               input logic fl, input logic r);
    @(negedge clk);
    #1;
    enq_valid = ev; enq_pc = pc; enq_global_pred = g; enq_local_pred = l;
    enq_final_pred = f; enq_bhr = bhr; res_valid = rv; res_taken = rt; flush = fl; rst = r;
    modelStep(ev, pc, g, l, f, bhr, rv, rt, fl, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic enqOk(input logic [31:0] pc);
    applyStimulus(1, pc, 1, 1, 1, 4'h5, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkEq("upd_valid", upd_valid, expUpdValid);
      checkEq("upd_br_en", upd_br_en, expBrEn);
      checkEq("upd_idx", upd_idx, expIdx);
      checkEq("upd_bhr", upd_bhr, expBhr);
      checkEq("upd_meta_valid", upd_meta_valid, expMetaValid);
      checkEq("upd_meta_to_global", upd_meta_to_global, expToGlobal);
      checkEq("mispredict", mispredict, expMis);
      checkEq("res_err", res_err, expResErr);
      checkEq("count", count, modelQ.size());
      checkEq("enq_ready", enq_ready, modelQ.size() < DEPTH);
      checkEq("stat_branches", stat_branches, expBranches);
      checkEq("stat_mispredicts", stat_mispredicts, expMispreds);
    end
  end

  initial begin
    rst = 1; enq_valid = 0; enq_pc = 0; enq_global_pred = 0; enq_local_pred = 0;
    enq_final_pred = 0; enq_bhr = 0; res_valid = 0; res_taken = 0; flush = 0;
    expBranches = 0; expMispreds = 0;

    doReset();
    doReset();
    checkEn = 1;
    checkEq("lit_reset_count", count, 0);
    checkEq("lit_reset_ready", enq_ready, 1);
    checkEq("lit_reset_upd", upd_valid, 0);

    // Fill to capacity, hold a fifth enqueue through the first resolve.
    for (int i = 0; i < 4; i++) enqOk(32'h100 + 32'(i) * 32'h40);
    checkEq("lit_full_count", count, 4);
    checkEq("lit_full_ready", enq_ready, 0);
    applyStimulus(1, 32'h200, 1, 1, 1, 4'h1, 0, 0, 0, 0);
    checkEq("lit_held_count", count, 4);
    applyStimulus(1, 32'h200, 1, 1, 1, 4'h1, 1, 1, 0, 0);
    checkEq("lit_pop_count", count, 3);
    applyStimulus(1, 32'h200, 1, 1, 1, 4'h1, 0, 0, 0, 0);
    checkEq("lit_fifth_count", count, 4);

    // Single mispredicted branch with disagreeing components.
    doReset();
    applyStimulus(1, 32'h0000_00C0, 1, 0, 0, 4'b1010, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkEq("lit_upd_valid", upd_valid, 1);
    checkEq("lit_br_en", upd_br_en, 1);
    checkEq("lit_idx", upd_idx, 4'h3);
    checkEq("lit_bhr", upd_bhr, 4'b1010);
    checkEq("lit_meta_valid", upd_meta_valid, 1);
    checkEq("lit_to_global", upd_meta_to_global, 1);
    checkEq("lit_mispredict", mispredict, 1);
    checkEq("lit_mis_count", count, 0);

    // Correct prediction, then a squashing mispredict with a dropped enqueue.
    doReset();
    for (int i = 0; i < 3; i++) enqOk(32'h400 + 32'(i) * 32'h40);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    checkEq("lit_ok_meta", upd_meta_valid, 0);
    checkEq("lit_ok_mis", mispredict, 0);
    checkEq("lit_ok_count", count, 2);
    checkEq("lit_ok_branches", stat_branches, 1);
    applyStimulus(1, 32'h800, 1, 1, 1, 0, 1, 0, 0, 0);
    checkEq("lit_squash_count", count, 0);
    checkEq("lit_squash_mis", stat_mispredicts, 1);

    // Resolve against an empty queue while enqueueing.
    doReset();
    applyStimulus(1, 32'h40, 0, 1, 1, 4'h2, 1, 1, 0, 0);
    checkEq("lit_err", res_err, 1);
    checkEq("lit_err_upd", upd_valid, 0);
    checkEq("lit_err_count", count, 1);

    // Flush with a correct resolve; then the same cycle with reset.
    doReset();
    for (int i = 0; i < 3; i++) enqOk(32'h40 * 32'(i));
    applyStimulus(1, 32'h900, 0, 0, 0, 0, 1, 1, 1, 0);
    checkEq("lit_flush_upd", upd_valid, 1);
    checkEq("lit_flush_count", count, 0);
    doReset();
    for (int i = 0; i < 3; i++) enqOk(32'h40 * 32'(i));
    applyStimulus(1, 32'h900, 0, 0, 0, 0, 1, 1, 1, 1);
    checkEq("lit_rst_upd", upd_valid, 0);
    checkEq("lit_rst_count", count, 0);
    checkEq("lit_rst_ready", enq_ready, 1);
    checkEq("lit_rst_stats", stat_branches, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 4'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
    end
    idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
